sig_dump_tx: RTL and testbench

Synthesizable end-of-test signature streamer for the RV32I pipeline on FPGA. It snoops CPU data stores for the `tohost` completion write, halts the CPU, and reads the signature region back out of the unified BRAM through a spare read port. Each word goes out as 8 lowercase hex ASCII characters plus a newline on a byte stream feeding the UART transmitter, so the signature file can be produced on hardware instead of only in simulation.

---
 rtl/sig_dump_tx.sv | 127 ++++++++++++
 tb/tb_sig_dump_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_dump_tx.sv
// End-of-test signature streamer: waits for the tohost completion store, halts the CPU,
// then reads the signature region from BRAM and sends each word as 8 hex chars + newline.
module sig_dump_tx #(
  parameter logic [31:0] SIG_BEGIN = 32'h0000_5000,
  parameter logic [31:0] SIG_END   = 32'h0000_8000,
  parameter logic [31:0] TOHOST    = 32'h0000_5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        cpu_halt,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] NL_IDX   = IDX_W'(8);
  localparam logic [IDX_W-1:0] LAST_HEX = IDX_W'(7);
  localparam logic [7:0]       ASCII_NL = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t           state;
  logic [31:0]      addr;
  logic [31:0]      word;
  logic [IDX_W-1:0] idx;

  logic        trig_c;
  logic [31:0] addr_next_c;

  assign trig_c      = st_valid && (st_addr == TOHOST) && (st_data == 32'h0000_0001);
  assign addr_next_c = addr + 32'd4;

  // Lowercase hex digit to ASCII.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h57 + {4'h0, n};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      addr     <= 32'h0;
      word     <= 32'h0;
      idx      <= '0;
      cpu_halt <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= 32'h0;
      tx_data  <= 8'h0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trig_c) begin
            cpu_halt <= 1'b1;
            addr     <= SIG_BEGIN;
            if (SIG_BEGIN >= SIG_END) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= SIG_BEGIN;
              state   <= S_READ;
            end
          end
        end
        S_READ: begin
          rd_en <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // rd_data is valid now; first character is preloaded so SEND starts valid.
          word     <= rd_data;
          idx      <= '0;
          tx_data  <= hex_char(rd_data[31:28]);
          tx_valid <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            if (idx == NL_IDX) begin
              tx_valid <= 1'b0;
              addr     <= addr_next_c;
              if (addr_next_c >= SIG_END) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                rd_en   <= 1'b1;
                rd_addr <= addr_next_c;
                state   <= S_READ;
              end
            end else begin
              idx     <= idx + IDX_W'(1);
              word    <= {word[27:0], 4'h0};
              tx_data <= (idx == LAST_HEX) ? ASCII_NL : hex_char(word[27:24]);
            end
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sig_dump_tx.sv
// Directed bench for sig_dump_tx: three instances cover the 2-word, 3-word and empty regions.
module tb_sig_dump_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = 32'h0, st_data = 32'h0;
  logic        tx_ready = 1'b1;

  logic        cpu_halt_a, rd_en_a, tx_valid_a, busy_a, done_a;
  logic [31:0] rd_addr_a, rd_data_a;
  logic [7:0]  tx_data_a;
  logic        cpu_halt_b, rd_en_b, tx_valid_b, busy_b, done_b;
  logic [31:0] rd_addr_b, rd_data_b;
  logic [7:0]  tx_data_b;
  logic        cpu_halt_c, rd_en_c, tx_valid_c, busy_c, done_c;
  logic [31:0] rd_addr_c;
  logic [31:0] rd_data_c = 32'h0;
  logic [7:0]  tx_data_c;

  sig_dump_tx #(.SIG_BEGIN(32'h5000), .SIG_END(32'h5008), .TOHOST(32'h5000)) dut_a (
    .clk(clk), .rst(rst_a), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .cpu_halt(cpu_halt_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready), .busy(busy_a), .done(done_a));

  sig_dump_tx #(.SIG_BEGIN(32'h5000), .SIG_END(32'h500C), .TOHOST(32'h5000)) dut_b (
    .clk(clk), .rst(rst_b), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .cpu_halt(cpu_halt_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready), .busy(busy_b), .done(done_b));

  sig_dump_tx #(.SIG_BEGIN(32'h5000), .SIG_END(32'h5000), .TOHOST(32'h5000)) dut_c (
    .clk(clk), .rst(rst_c), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .cpu_halt(cpu_halt_c), .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready), .busy(busy_c), .done(done_c));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h5000: return 32'h0000_0001;
      32'h5004: return 32'hDEAD_BEEF;
      32'h5008: return 32'h0123_ABCD;
      default:  return 32'h0;
    endcase
  endfunction

  // One-cycle-latency BRAM models
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem_word(rd_addr_a);
    if (rd_en_b) rd_data_b <= mem_word(rd_addr_b);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Monitor state; cleared through a request/ack counter pair
  logic [7:0]  bytes_a[$];
  logic [31:0] addrs_a[$];
  int rd_cnt_a = 0, val_cnt_a = 0, viol_a = 0, stall_a = 0, bytes_b = 0, act_c = 0;
  int clr_req = 0, clr_ack = 0;
  logic       pend = 1'b0;
  logic [7:0] pd = 8'h0;

  always @(posedge clk) begin
    if (clr_req != clr_ack) begin
      bytes_a.delete();
      addrs_a.delete();
      rd_cnt_a = 0; val_cnt_a = 0; viol_a = 0; stall_a = 0;
      clr_ack = clr_req;
    end
    if (rst_a) pend = 1'b0;
    else begin
      if (tx_valid_a && tx_ready) bytes_a.push_back(tx_data_a);
      if (rd_en_a) begin addrs_a.push_back(rd_addr_a); rd_cnt_a++; end
      if (tx_valid_a) val_cnt_a++;
      if (tx_valid_a && !tx_ready) stall_a++;
      if (pend && (!tx_valid_a || tx_data_a !== pd)) viol_a++;
      pend = tx_valid_a && !tx_ready;
      pd   = tx_data_a;
    end
    if (!rst_b && tx_valid_b && tx_ready) bytes_b++;
    if (!rst_c && (tx_valid_c || rd_en_c)) act_c++;
  end

  task automatic clear_mon();
    clr_req++;
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic v);
    st_addr = a; st_data = d; st_valid = v;
    @(negedge clk);
    st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
  endtask

  task automatic wait_done_a(input string tag, input int limit);
    int n = 0;
    while (!done_a && n < limit) begin @(negedge clk); n++; end
    check({tag, "_timeout"}, 32'(done_a), 1);
  endtask

  task automatic check_stream(input string tag);
    string exp = "00000001\ndeadbeef\n";
    check({tag, "_len"}, 32'(bytes_a.size()), 18);
    for (int i = 0; i < 18; i++)
      if (i < bytes_a.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(bytes_a[i]), 32'(exp[i]));
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_halt"},  32'(cpu_halt_a), 0);
    check({tag, "_rden"},  32'(rd_en_a),    0);
    check({tag, "_valid"}, 32'(tx_valid_a), 0);
    check({tag, "_busy"},  32'(busy_a),     0);
    check({tag, "_done"},  32'(done_a),     0);
    check({tag, "_addr"},  rd_addr_a,       0);
    check({tag, "_data"},  32'(tx_data_a),  0);
  endtask

  initial begin
    int n;
    int rise;
    logic stretched;

    repeat (3) @(negedge clk);
    check_zero_a("reset");

    // Trigger store while reset is held: reset wins
    store(32'h5000, 32'h1, 1'b1);
    check("rst_trig_halt", 32'(cpu_halt_a), 0);
    rst_a = 1'b0;
    @(negedge clk);

    // Non-triggering stores
    clear_mon();
    store(32'h5000, 32'h2, 1'b1);
    store(32'h5004, 32'h1, 1'b1);
    store(32'h5000, 32'h1, 1'b0);
    repeat (3) @(negedge clk);
    check("nt_halt", 32'(cpu_halt_a), 0);
    check("nt_busy", 32'(busy_a), 0);
    check("nt_valid_cycles", 32'(val_cnt_a), 0);
    check("nt_rd_cycles", 32'(rd_cnt_a), 0);

    // Two-word dump, tx_ready held high
    clear_mon();
    tx_ready = 1'b1;
    store(32'h5000, 32'h1, 1'b1);
    wait_done_a("dump", 200);
    check("dump_busy", 32'(busy_a), 0);
    check("dump_halt", 32'(cpu_halt_a), 1);
    check("dump_valid", 32'(tx_valid_a), 0);
    check_stream("dump");
    check("dump_nrd", 32'(addrs_a.size()), 2);
    if (addrs_a.size() == 2) begin
      check("dump_rd0", addrs_a[0], 32'h5000);
      check("dump_rd1", addrs_a[1], 32'h5004);
    end

    // Stores after done are ignored
    clear_mon();
    store(32'h5000, 32'h1, 1'b1);
    repeat (20) @(negedge clk);
    check("post_rd", 32'(rd_cnt_a), 0);
    check("post_valid", 32'(val_cnt_a), 0);
    check("post_done", 32'(done_a), 1);

    // Reset mid-dump after 4 bytes, then a fresh dump
    rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    clear_mon();
    store(32'h5000, 32'h1, 1'b1);
    n = 0;
    while (bytes_a.size() < 4 && n < 100) begin @(negedge clk); n++; end
    check("mid_4bytes", 32'(bytes_a.size()), 4);
    #1 rst_a = 1'b1;
    #1 check_zero_a("mid_rst");
    @(negedge clk);
    rst_a = 1'b0;
    clear_mon();
    store(32'h5000, 32'h1, 1'b1);
    wait_done_a("redump", 200);
    check_stream("redump");

    // Backpressure: random 30% ready plus a 20-cycle stall mid-word
    rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    clear_mon();
    store(32'h5000, 32'h1, 1'b1);
    stretched = 1'b0;
    n = 0;
    while (!done_a && n < 3000) begin
      if (bytes_a.size() >= 12 && !stretched) begin
        tx_ready = 1'b0;
        repeat (20) @(negedge clk);
        stretched = 1'b1;
        n += 20;
      end else begin
        tx_ready = ($urandom_range(0, 9) < 3);
        @(negedge clk);
        n++;
      end
    end
    tx_ready = 1'b1;
    check("bp_timeout", 32'(done_a), 1);
    check("bp_stable", 32'(viol_a), 0);
    check("bp_stalls_seen", 32'(stall_a > 20), 1);
    check_stream("bp");

    // Exact cycle count: three words
    rst_a = 1'b1;
    rst_b = 1'b0;
    @(negedge clk);
    st_addr = 32'h5000; st_data = 32'h1; st_valid = 1'b1;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    check("cnt_halt", 32'(cpu_halt_b), 1);
    check("cnt_busy", 32'(busy_b), 1);
    check("cnt_rden", 32'(rd_en_b), 1);
    check("cnt_rdaddr", rd_addr_b, 32'h5000);
    rise = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done_b && rise == 0) rise = i;
    end
    check("cnt_done_edge", 32'(rise), 33);
    check("cnt_bytes", 32'(bytes_b), 27);

    // Empty region
    @(negedge clk);
    rst_b = 1'b1;
    rst_c = 1'b0;
    @(negedge clk);
    st_addr = 32'h5000; st_data = 32'h1; st_valid = 1'b1;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    check("empty_done", 32'(done_c), 1);
    check("empty_busy", 32'(busy_c), 0);
    check("empty_halt", 32'(cpu_halt_c), 1);
    check("empty_valid", 32'(tx_valid_c), 0);
    repeat (10) @(negedge clk);
    check("empty_activity", 32'(act_c), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
